// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
// Shared storage primitive for the FIFO family; contents are never reset.
module sync_fifo_ram #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_DEPTH      = 16,
    localparam int ADDR_W      = $clog2(P_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [P_DATA_WIDTH-1:0] rdata
);

    logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy count, almost flags,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_DEPTH      = 16,
    parameter int P_AFULL      = P_DEPTH - 2,
    parameter int P_AEMPTY     = 2,
    localparam int ADDR_W      = $clog2(P_DEPTH),
    localparam int CNT_W       = ADDR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    write,
    input  logic [P_DATA_WIDTH-1:0] data_in,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    read,
    output logic [P_DATA_WIDTH-1:0] data_out,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [CNT_W-1:0]        count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_err
);

    if (P_DEPTH < 2 || (P_DEPTH & (P_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: P_DEPTH must be a power of two >= 2");
    end
    if (P_AFULL < 1 || P_AFULL > P_DEPTH) begin : g_bad_afull
        $error("sync_fifo: P_AFULL must be in 1..P_DEPTH");
    end
    if (P_AEMPTY >= P_DEPTH) begin : g_bad_aempty
        $error("sync_fifo: P_AEMPTY must be < P_DEPTH");
    end

    logic [CNT_W-1:0] wr_ptr, rd_ptr;
    logic             rd_ok, wr_ok;

    // Flags come only from the registered count, never from this cycle's inputs.
    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(P_DEPTH));
    assign almost_full  = (count >= CNT_W'(P_AFULL));
    assign almost_empty = (count <= CNT_W'(P_AEMPTY));

    // A write into a full FIFO is taken only when a read frees the head slot.
    assign rd_ok = read && !empty;
    assign wr_ok = write && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + CNT_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + CNT_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Set wins over clear; flush neither sets nor clears the error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (write && !wr_ok && !flush) || (overflow && !clear_err);
            underflow <= (read && empty && !flush) || (underflow && !clear_err);
        end
    end

    // The wrap bits are kept for pointer symmetry with the CDC family; occupancy
    // here comes from count, so they do not feed any logic.
    logic unused_wrap;
    assign unused_wrap = wr_ptr[ADDR_W] ^ rd_ptr[ADDR_W];

    sync_fifo_ram #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_DEPTH      (P_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !flush),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (32 x 16): fill, full boundary, drain, errors,
// flush priority, async reset mid-burst and pointer wrap.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        write = 1'b0;
    logic [31:0] data_in = '0;
    logic        full, almost_full;
    logic        read = 1'b0;
    logic [31:0] data_out;
    logic        empty, almost_empty;
    logic [4:0]  count;
    logic        overflow, underflow;
    logic        clear_err = 1'b0;

    int errors = 0;
    int checks = 0;

    sync_fifo #(.P_DATA_WIDTH(32), .P_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .write        (write),
        .data_in      (data_in),
        .full         (full),
        .almost_full  (almost_full),
        .read         (read),
        .data_out     (data_out),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply whatever inputs are set up, take one edge, then release the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);

        // Fill 0x100..0x10F
        for (int i = 0; i < 16; i++) begin
            write = 1'b1; data_in = 32'h100 + 32'(i);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
            check("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
            check("fill_full", 32'(full), 32'(i + 1 == 16));
            check("fill_head", data_out, 32'h100);
        end

        // Write while full, alone: rejected
        write = 1'b1; data_in = 32'h999;
        tick();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_head", data_out, 32'h100);

        // Read+write while full: both accepted
        write = 1'b1; read = 1'b1; data_in = 32'h200;
        tick();
        check("rw_full_count", 32'(count), 32'd16);
        check("rw_full_head", data_out, 32'h101);
        check("rw_full_full", 32'(full), 32'd1);

        // Drain
        for (int i = 0; i < 16; i++) begin
            check("drain_data", data_out, (i < 15) ? 32'h101 + 32'(i) : 32'h200);
            read = 1'b1;
            tick();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_udf_clear", 32'(underflow), 32'd0);

        read = 1'b1;
        tick();
        check("udf_set", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        clear_err = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_udf", 32'(underflow), 32'd0);

        // Read+write on empty: only the write is taken
        read = 1'b1; write = 1'b1; data_in = 32'hABC;
        tick();
        check("erw_count", 32'(count), 32'd1);
        check("erw_head", data_out, 32'hABC);
        check("erw_udf", 32'(underflow), 32'd1);
        check("erw_empty", 32'(empty), 32'd0);

        // Set wins over clear
        read = 1'b1; clear_err = 1'b1;
        tick();
        check("set_over_clr_count", 32'(count), 32'd0);
        read = 1'b1; clear_err = 1'b1;
        tick();
        check("set_over_clr", 32'(underflow), 32'd1);
        clear_err = 1'b1;
        tick();
        check("clr_again", 32'(underflow), 32'd0);

        // Half fill, then flush with read and write
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; data_in = 32'h300 + 32'(i);
            tick();
        end
        check("half_count", 32'(count), 32'd8);
        flush = 1'b1; write = 1'b1; read = 1'b1; data_in = 32'h777;
        tick();
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_ovf", 32'(overflow), 32'd0);
        flush = 1'b1; read = 1'b1;
        tick();
        check("flush_no_udf", 32'(underflow), 32'd0);
        write = 1'b1; data_in = 32'h555;
        tick();
        check("post_flush_count", 32'(count), 32'd1);
        check("post_flush_head", data_out, 32'h555);

        // Async reset between edges
        write = 1'b1; data_in = 32'h600;
        tick();
        write = 1'b1; data_in = 32'h601;
        write = 1'b1;
        tick();
        check("pre_rst_count", 32'(count), 32'd3);
        write = 1'b1; data_in = 32'h602;
        tick();
        write = 1'b1; data_in = 32'h603;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_aempty", 32'(almost_empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        write = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("arst_hold", 32'(count), 32'd0);

        // Pointer wrap: one word buffered, 40 simultaneous push/pop pairs
        write = 1'b1; data_in = 32'h400;
        tick();
        for (int i = 1; i <= 40; i++) begin
            write = 1'b1; read = 1'b1; data_in = 32'h400 + 32'(i);
            tick();
            check("wrap_head", data_out, 32'h400 + 32'(i));
            check("wrap_count", 32'(count), 32'd1);
        end
        read = 1'b1;
        tick();
        check("wrap_final_empty", 32'(empty), 32'd1);
        check("wrap_no_udf", 32'(underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
